decoder: RTL
============

# decoder

Second pipeline stage of the RV32I core, directly downstream of the fetch stage. It consumes the fetched instruction word and its address, reads the 32×32 register file (held inside this block, written by writeback), decodes control fields and the immediate, and registers everything into the decode/execute pipeline register. It also detects load-use hazards and drives `bubble_from_decoder` back to fetch to hold the PC, and squashes wrong-path instructions on a taken branch or jump.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 32: instruction word from fetch.
- `inst_pc` in 32: address of `instruction`; connect to fetch `npc`.
- `flush` in 1: taken branch or jump resolved in execute, asserted for one cycle.
- `wb_en` in 1: register-file write enable.
- `wb_rd` in 5: write index.
- `wb_data` in 32: write data.
- `bubble_from_decoder` out 1: combinational; holds the fetch PC this cycle.
- `ex_valid` out 1: execute register holds a real instruction.
- `ex_pc` out 32: address of that instruction.
- `ex_rs1_data`, `ex_rs2_data` out 32 each: register operands.
- `ex_imm` out 32: sign-extended immediate.
- `ex_rd`, `ex_rs1`, `ex_rs2` out 5 each: register indices.
- `ex_alu_op` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- `ex_alu_src_imm` out 1: ALU operand B is the immediate.
- `ex_mem_read`, `ex_mem_write` out 1 each: load or store.
- `ex_funct3` out 3: branch condition or memory size.
- `ex_reg_write` out 1: writes `rd`.
- `ex_wb_sel` out 2: 0 ALU, 1 memory, 2 PC+4.
- `ex_branch`, `ex_jal`, `ex_jalr` out 1 each: control-transfer type.
- `ex_illegal` out 1: unsupported opcode.

## Operation
- **Warm-up counter (2 bits).**
  - `rst` clears it to 0.
  - It increments on each edge with `rst` low and saturates at 3.
  - Input is ignored (treated as invalid) while the counter is below 3.
  - This matches the fetch start-up delay: the first instruction (address 0) is presented on the cycle after the third edge with `rst` low.
- **Decode.**
  - Opcodes handled: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate formats: I, S, B, U, J, each sign-extended to 32 bits.
  - `ex_alu_op` comes from funct3 plus funct7[5]. For OP-IMM, funct7[5] is used only for shifts.
  - LUI uses PASS_B. AUIPC, loads, stores, JAL and JALR use ADD.
  - Any other opcode sets `ex_illegal`=1 with `ex_reg_write`=0, `ex_mem_read`=0 and `ex_mem_write`=0. `ex_valid` stays 1.
  - `ex_reg_write` is forced to 0 when rd=x0.
- **Register file.**
  - x0 reads 0, and writes to it are ignored.
  - Write-first bypass: if `wb_en` is set and `wb_rd` equals a source index (non-zero), the read returns `wb_data` in the same cycle.
- **Load-use hazard.**
  - Condition: input is valid, `ex_valid`=1, `ex_mem_read`=1, `ex_rd`≠0, and `ex_rd` matches rs1 or rs2 used by the current instruction.
  - On the hazard, `bubble_from_decoder`=1, and the execute register loads a NOP (`ex_valid`=0, all enables 0).
  - The current instruction and `inst_pc` are captured in a hold register and `replay` is set.
- **Replay.**
  - On the cycle after a bubble, the held instruction is decoded and the `instruction` input is discarded. The fetch PC hold makes that input reappear on the following cycle.
  - `replay` clears after one cycle.
- **Flush.**
  - `flush` at cycle t squashes the input at t and at t+1 (via a registered `flush_d`), because one wrong-path instruction is already in the fetch pipe.
  - The execute register loads a NOP on both edges, and `replay` is cleared.
  - `bubble_from_decoder` is forced to 0 while `flush` or `flush_d` is set.
  - Flush has priority over hazard and over replay.

## Timing
- **Reset values.**
  - All `ex_*` outputs are 0.
  - `replay`, `flush_d` and the warm-up counter are 0.
  - The register file is cleared to 0 (32 entries).
- **Latency.** One cycle from input to `ex_*`.
- **Bubble path.** `bubble_from_decoder` is combinational from the inputs and the `ex_*` registers. It is never asserted during warm-up, replay, `rst`, or flush.
- **Writeback vs. decode.** A write at cycle t is visible to a decode at cycle t through the bypass.
- **Reset mid-stall.** `rst` during a stall drops the held instruction.

## Test plan
- **Warm-up:** release `rst`, present `addi x1,x0,5` on the fourth cycle → `ex_valid`=1, `ex_imm`=5, `ex_rd`=1, `ex_alu_op`=0, `ex_alu_src_imm`=1. The three earlier cycles give `ex_valid`=0.
- **Bypass:** `wb_en`=1, `wb_rd`=3, `wb_data`=0xDEADBEEF while decoding `add x4,x3,x0` → `ex_rs1_data`=0xDEADBEEF. Writing x0 with 7 and then reading it → 0.
- **Load-use:** `lw x5,0(x2)` then `add x6,x5,x1` → `bubble_from_decoder`=1 for one cycle, one NOP, then `add` issues with `ex_pc` equal to its own address. The repeated input is discarded, and the next instruction issues once.
- **Flush:** `flush`=1 at cycle t → `ex_valid`=0 at edges t+1 and t+2, and the correct-path instruction issues at t+3. `flush` asserted during a replay cycle → the held instruction is dropped.
- **Immediates:** `beq` with offset -4 → `ex_imm`=0xFFFFFFFC. `jal` with offset 0x800 → `ex_imm`=0x800, `ex_wb_sel`=2. `lui x7,0x12345` → `ex_imm`=0x12345000, `ex_alu_op`=10. `sw` with offset -1 → `ex_imm`=0xFFFFFFFF.
- **Illegal:** opcode 0x7F → `ex_illegal`=1 with `ex_reg_write`, `ex_mem_read` and `ex_mem_write` all 0. `srai x1,x1,3` → `ex_alu_op`=7.

Source files
------------

// File: rtl/decoder.sv
// rtl/decoder.sv - RV32I decode stage: register file, control/immediate decode, load-use stall, flush squash
// Ports:
//   clk, rst              : clock; synchronous active-high reset
//   instruction, inst_pc  : fetched word and its address (fetch npc)
//   flush                 : taken branch/jump resolved in execute, one-cycle pulse
//   wb_en, wb_rd, wb_data : register-file write port from writeback
//   bubble_from_decoder   : combinational request to fetch to hold its PC this cycle
//   ex_*                  : decode/execute pipeline register contents
`timescale 1ns/1ps
module decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] inst_pc,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        bubble_from_decoder,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src_imm,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [2:0]  ex_funct3,
  output logic        ex_reg_write,
  output logic [1:0]  ex_wb_sel,
  output logic        ex_branch,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } ex_t;

  logic [1:0]  warm_q, warm_d;
  logic        replay_q, replay_d;
  logic        flush_d_q, flush_d_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  ex_t         ex_q, ex_d;

  logic [31:0] cur_inst, cur_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        uses_rs1, uses_rs2;
  logic        warm_done, squash, cur_valid, hazard;
  ex_t         dec;

  // alt_sub selects SUB for funct3=0; alt_shift selects SRA for funct3=5.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic alt_sub,
                                                 input logic alt_shift);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt_sub ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt_shift ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // During replay the held word is decoded and the live input is ignored.
  always_comb begin : field_extract
    cur_inst = replay_q ? hold_inst_q : instruction;
    cur_pc   = replay_q ? hold_pc_q : inst_pc;
    opcode   = cur_inst[6:0];
    rd       = cur_inst[11:7];
    funct3   = cur_inst[14:12];
    rs1      = cur_inst[19:15];
    rs2      = cur_inst[24:20];
    f7_alt   = cur_inst[30];
    imm_i    = {{20{cur_inst[31]}}, cur_inst[31:20]};
    imm_s    = {{20{cur_inst[31]}}, cur_inst[31:25], cur_inst[11:7]};
    imm_b    = {{19{cur_inst[31]}}, cur_inst[31], cur_inst[7], cur_inst[30:25],
                cur_inst[11:8], 1'b0};
    imm_u    = {cur_inst[31:12], 12'b0};
    imm_j    = {{11{cur_inst[31]}}, cur_inst[31], cur_inst[19:12], cur_inst[20],
                cur_inst[30:21], 1'b0};
  end

  // Write-first read: a same-cycle writeback is forwarded; x0 always reads zero.
  always_comb begin : rf_read
    rs1_data = rf_q[rs1];
    if (wb_en && (wb_rd == rs1)) rs1_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    rs2_data = rf_q[rs2];
    if (wb_en && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  always_comb begin : decode
    dec          = '0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    dec.valid    = 1'b1;
    dec.pc       = cur_pc;
    dec.rd       = rd;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.funct3   = funct3;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    case (opcode)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.wb_sel = WB_PC4; dec.jal = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.wb_sel = WB_PC4; dec.jalr = 1'b1; uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1; dec.wb_sel = WB_MEM; uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        // funct7[5] of an I-type is immediate bit 10; it only means SRA for shifts.
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, 1'b0, f7_alt); uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        dec.reg_write = 1'b1; dec.alu_op = alu_from_funct3(funct3, f7_alt, f7_alt);
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec.reg_write = 1'b0;
  end

  always_comb begin : control
    warm_done = (warm_q == 2'd3);
    // flush_d covers the one wrong-path word already inside fetch.
    squash    = flush | flush_d_q;
    cur_valid = warm_done & ~squash & ~rst;
    // A replayed word always follows a NOP, so it can never hazard again.
    hazard    = cur_valid & ~replay_q & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));
    bubble_from_decoder = hazard;
  end

  always_comb begin : next_state
    warm_d      = warm_done ? warm_q : warm_q + 2'd1;
    flush_d_d   = flush;
    replay_d    = hazard;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    if (hazard) begin
      hold_inst_d = instruction;
      hold_pc_d   = inst_pc;
    end
    ex_d = (cur_valid && !hazard) ? dec : '0;
    for (int i = 0; i < 32; i++) rf_d[i] = rf_q[i];
    if (wb_en && (wb_rd != 5'd0)) rf_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q      <= '0;
      replay_q    <= 1'b0;
      flush_d_q   <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      ex_q        <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      warm_q      <= warm_d;
      replay_q    <= replay_d;
      flush_d_q   <= flush_d_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      ex_q        <= ex_d;
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_rs1_data    = ex_q.rs1_data;
  assign ex_rs2_data    = ex_q.rs2_data;
  assign ex_imm         = ex_q.imm;
  assign ex_rd          = ex_q.rd;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_funct3      = ex_q.funct3;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_wb_sel      = ex_q.wb_sel;
  assign ex_branch      = ex_q.branch;
  assign ex_jal         = ex_q.jal;
  assign ex_jalr        = ex_q.jalr;
  assign ex_illegal     = ex_q.illegal;

endmodule
